stage_if: RTL and testbench
===========================

# stage_if

Instruction-fetch stage of the five-stage ARM-subset pipeline, upstream of the IF/ID register that feeds the decode stage. It holds the program counter and fetches words from a variable-latency instruction memory over a request/ready handshake. It presents `{pcOut = PC+4, inst}` with a valid flag. It honours the hazard freeze and executes branch redirects from EX, including squashing a fetch already in flight.

## Interface
- Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `freeze` in 1: hazard stall; the IF/ID register does not accept this cycle.
- `branchTaken` in 1: one-cycle redirect pulse from EX.
- `branchAddr` in 32: redirect target; bits [1:0] are ignored and treated as 0.
- `imemReq` out 1: instruction-memory request.
- `imemAddr` out 32: request address; stable while `imemReq`=1.
- `imemReady` in 1: memory returns `imemRdata` this cycle; may coincide with the first cycle of `imemReq`.
- `imemRdata` in 32: fetched instruction word.
- `pcOut` out 32: address of the presented instruction + 4.
- `inst` out 32: presented instruction.
- `instValid` out 1: `pcOut`/`inst` are meaningful.

## Operation
- Registers:
- `pc`: next address to fetch.
- `reqAddr`: drives `imemAddr`.
- Output buffer `{bufPc, bufInst, bufValid}`: drives `pcOut`, `inst` and `instValid`.
- One-entry skid buffer `{skPc, skInst}`.
- `consume` = `bufValid & ~freeze`. The buffer entry leaves on the edge where `consume`=1.
- State IDLE (`imemReq`=0): go to BUSY with `reqAddr`<=`pc` on the next edge.
- State BUSY (`imemReq`=1): once raised, the request and `imemAddr` are held until `imemReady`=1.
  - On `imemReady`, if `bufValid`=0 or `consume`=1: load the buffer with {`reqAddr`+4, `imemRdata`}, set `pc`<=`reqAddr`+4 and `reqAddr`<=`reqAddr`+4, and stay in BUSY (back-to-back fetch).
  - On `imemReady` otherwise: load the skid buffer, set `pc`<=`reqAddr`+4, and go to SKID.
- State SKID (`imemReq`=0): on `consume`, move the skid entry into the buffer (`bufValid` stays 1), set `reqAddr`<=`pc`, and go to BUSY.
- State DRAIN (`imemReq`=1, holding the old `reqAddr`): a squashed fetch completes here. On `imemReady` the data is discarded, `reqAddr`<=`pc`, and the state goes to BUSY.
- Branch (`branchTaken`=1 at an edge) has priority over everything, including `freeze`.
  - `bufValid`<=0 and the skid entry is dropped.
  - `pc`<=`{branchAddr[31:2],2'b00}`.
  - From BUSY with `imemReady`=0: go to DRAIN.
  - From BUSY with `imemReady`=1: discard the returned data, set `reqAddr`<=target, and go to BUSY.
  - From IDLE or SKID: set `reqAddr`<=target and go to BUSY.
  - From DRAIN: stay in DRAIN with the new `pc`; the last target wins.
- Arithmetic: all PC math is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Nothing is fetched twice or skipped. At most 2 instructions are buffered.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State IDLE; `pc`=`RESET_PC`; `reqAddr`=`RESET_PC`.
  - `imemReq`=0, `imemAddr`=`RESET_PC`, `pcOut`=0, `inst`=0, `instValid`=0; skid buffer empty.
- Reset mid-request abandons the request. Memory must tolerate `imemReq` dropping.
- `imemReq` and `imemAddr` are decoded from registered state only; there is no combinational path from `imemReady` to them.
- `instValid`, `pcOut` and `inst` are registered.
- Latency: instruction data appears on the outputs 1 cycle after the `imemReady` edge.
- Zero-wait memory:
  - 1st cycle after reset release: IDLE.
  - 2nd cycle: request at `RESET_PC`.
  - 3rd cycle: `instValid`=1, `pcOut`=`RESET_PC`+4.
  - One instruction per cycle thereafter.
- N-wait memory: one instruction per N+1 cycles.
- Outputs hold while `freeze`=1 and `bufValid`=1.
- Branch-redirect penalty with zero-wait memory: `instValid`=0 for one cycle after the branch edge; the target instruction is valid on the second cycle.

## Test plan
- Zero-wait memory returning word = address, no freeze: after reset, `instValid` rises in the 3rd cycle with `pcOut`=4 and `inst`=0. The following cycles present `pcOut` 8, 12, 16 with `inst` 4, 8, 12, one per cycle.
- 2-wait memory: `imemReq`/`imemAddr`=0 held for 3 cycles; instructions presented every 3 cycles; `imemAddr` never changes mid-request.
- `freeze` high for 4 cycles during streaming:
  - The buffer holds `pcOut`=12 and the skid buffer takes `pcOut`=16.
  - `imemReq` drops in SKID.
  - After release, 12, 16 and 20 are presented in order with no duplicate or gap.
- `branchTaken` with `branchAddr`=32'h100 while a 3-wait fetch to 0x8 is in flight:
  - `imemReq` is held at 0x8 until ready, and that data is discarded.
  - The next request is 0x100; the next valid output has `pcOut`=0x104.
- `branchTaken` with `freeze`=1 and both buffers full (`branchAddr`=32'h203): `instValid`=0 on the next cycle, followed by a fetch at 0x200.
- `RESET_PC`=32'hFFFF_FFF8 with zero-wait memory: `pcOut` presents FFFF_FFFC, then 0, then 4. Asserting `rst` mid-stream returns all outputs to their reset values immediately.

Source files
------------

// File: rtl/stage_if_if.sv
// Bundle between the fetch stage and its neighbours: hazard/redirect inputs,
// instruction-memory handshake and the registered IF/ID-facing outputs.
interface stage_if_if;
  logic        freeze;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic [31:0] pcOut;
  logic [31:0] inst;
  logic        instValid;

  modport master (
    input  freeze, branchTaken, branchAddr, imemReady, imemRdata,
    output imemReq, imemAddr, pcOut, inst, instValid
  );

  modport slave (
    output freeze, branchTaken, branchAddr, imemReady, imemRdata,
    input  imemReq, imemAddr, pcOut, inst, instValid
  );
endinterface

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, output buffer
// plus one-entry skid buffer, freeze handling and branch redirect with squash.
//
// state | meaning
// IDLE  | no request; next edge starts a fetch at pc
// BUSY  | request at reqAddr held until imemReady
// SKID  | output frozen and skid entry full; no request
// DRAIN | squashed fetch still outstanding; its data is discarded
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  stage_if_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_SKID  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] sk_pc_q, sk_pc_d;
  logic [31:0] sk_inst_q, sk_inst_d;

  logic        consume;
  logic [31:0] req_next;
  logic [31:0] target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_pc_q    <= 32'd0;
      buf_inst_q  <= 32'd0;
      buf_valid_q <= 1'b0;
      sk_pc_q     <= 32'd0;
      sk_inst_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      buf_valid_q <= buf_valid_d;
      sk_pc_q     <= sk_pc_d;
      sk_inst_q   <= sk_inst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    buf_valid_d = buf_valid_q;
    sk_pc_d     = sk_pc_q;
    sk_inst_d   = sk_inst_q;

    consume  = buf_valid_q & ~bus.freeze;
    req_next = req_addr_q + 32'd4;
    target   = bus.branchAddr & 32'hFFFF_FFFC;

    if (consume) begin
      buf_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        req_addr_d = pc_q;
        state_d    = ST_BUSY;
      end
      ST_BUSY: begin
        if (bus.imemReady) begin
          pc_d = req_next;
          if (!buf_valid_q || consume) begin
            buf_pc_d    = req_next;
            buf_inst_d  = bus.imemRdata;
            buf_valid_d = 1'b1;
            req_addr_d  = req_next;
          end else begin
            sk_pc_d   = req_next;
            sk_inst_d = bus.imemRdata;
            state_d   = ST_SKID;
          end
        end
      end
      ST_SKID: begin
        if (consume) begin
          buf_pc_d    = sk_pc_q;
          buf_inst_d  = sk_inst_q;
          buf_valid_d = 1'b1;
          req_addr_d  = pc_q;
          state_d     = ST_BUSY;
        end
      end
      ST_DRAIN: begin
        if (bus.imemReady) begin
          req_addr_d = pc_q;
          state_d    = ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect wins over freeze and over any buffer movement this edge.
    // A squashed fetch that completes on the redirect edge needs no drain.
    if (bus.branchTaken) begin
      buf_valid_d = 1'b0;
      pc_d        = target;
      if ((state_q == ST_BUSY || state_q == ST_DRAIN) && !bus.imemReady) begin
        req_addr_d = req_addr_q;
        state_d    = ST_DRAIN;
      end else begin
        req_addr_d = target;
        state_d    = ST_BUSY;
      end
    end
  end

  assign bus.imemReq   = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
  assign bus.imemAddr  = req_addr_q;
  assign bus.pcOut     = buf_pc_q;
  assign bus.inst      = buf_inst_q;
  assign bus.instValid = buf_valid_q;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed timing scenarios plus a randomized run checked
// against an in-order fetch-stream scoreboard driven by a wait-state memory model.
module tb_stage_if;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_w = 1'b1;
  always #5 clk = ~clk;

  stage_if_if bus ();
  stage_if_if bw ();

  stage_if u_dut (.clk(clk), .rst(rst), .bus(bus));
  stage_if #(.RESET_PC(32'hFFFF_FFF8)) u_dut_w (.clk(clk), .rst(rst_w), .bus(bw));

  assign bw.freeze      = 1'b0;
  assign bw.branchTaken = 1'b0;
  assign bw.branchAddr  = 32'd0;
  assign bw.imemReady   = 1'b1;
  assign bw.imemRdata   = bw.imemAddr;

  int          n_checks = 0;
  int          n_errors = 0;
  int          mem_wait;
  logic [31:0] key;
  bit          sb_on = 1'b0;
  bit          pending, last_ready;
  int          cnt;
  logic [31:0] hold;
  logic [31:0] exp_pc;
  int          idle_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ key;
  endfunction

  // Memory: each new request gets a wait count; ready rises when it hits 0.
  task automatic mem_eval();
    if (pending && last_ready) pending = 1'b0;
    if (bus.imemReq) begin
      if (!pending) begin
        pending = 1'b1;
        hold    = bus.imemAddr;
        cnt     = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
      end else begin
        chk("addr_stable", bus.imemAddr, hold);
        cnt--;
      end
    end else begin
      if (pending) chk("req_drop", 32'(bus.imemReq), 32'd1);
      pending = 1'b0;
    end
    last_ready    = pending && (cnt == 0);
    bus.imemReady = last_ready;
    bus.imemRdata = last_ready ? memf(hold) : $urandom;
  endtask

  // Reference: the presented stream is consecutive words from the last redirect.
  task automatic score();
    if (bus.branchTaken) begin
      exp_pc   = bus.branchAddr & 32'hFFFF_FFFC;
      idle_cnt = 0;
    end else if (bus.instValid) begin
      idle_cnt = 0;
      if (!bus.freeze) begin
        chk("sb_pc", bus.pcOut, exp_pc + 32'd4);
        chk("sb_inst", bus.inst, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
    end else begin
      idle_cnt++;
      if (idle_cnt > 40) begin
        chk("progress", 32'(idle_cnt), 32'd0);
        idle_cnt = 0;
      end
    end
  endtask

  task automatic tick(input logic frz, input logic br, input logic [31:0] ba);
    mem_eval();
    bus.freeze      = frz;
    bus.branchTaken = br;
    bus.branchAddr  = ba;
    if (sb_on) score();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.freeze      = 1'b0;
    bus.branchTaken = 1'b0;
    bus.branchAddr  = 32'd0;
    bus.imemReady   = 1'b0;
    rst             = 1'b1;
    pending         = 1'b0;
    last_ready      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, 32'(bus.instValid), 32'(v));
    if (v) begin
      chk({tag, "_pc"}, bus.pcOut, pc);
      chk({tag, "_inst"}, bus.inst, ins);
    end
  endtask

  initial begin
    bus.freeze = 1'b0; bus.branchTaken = 1'b0; bus.branchAddr = 32'd0;
    bus.imemReady = 1'b0; bus.imemRdata = 32'd0;
    pending = 1'b0; last_ready = 1'b0; key = 32'd0; mem_wait = 0;
    @(negedge clk);
    chk("rst_req", 32'(bus.imemReq), 32'd0);
    chk("rst_addr", bus.imemAddr, 32'd0);
    chk("rst_pc", bus.pcOut, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_valid", 32'(bus.instValid), 32'd0);

    // zero-wait streaming
    mem_wait = 0; key = 32'd0;
    do_reset();
    chk("z_idle", 32'(bus.imemReq), 32'd0);
    tick(0, 0, 0);
    chk("z_req", 32'(bus.imemReq), 32'd1);
    chk("z_addr", bus.imemAddr, 32'd0);
    chk_out("z_first", 1'b0, 0, 0);
    tick(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk_out("z_stream", 1'b1, 32'(4 + 4 * i), 32'(4 * i));
      tick(0, 0, 0);
    end

    // 2-wait memory
    mem_wait = 2;
    do_reset();
    tick(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("w2_req", 32'(bus.imemReq), 32'd1);
      chk("w2_addr", bus.imemAddr, 32'd0);
      chk_out("w2_wait", 1'b0, 0, 0);
      tick(0, 0, 0);
    end
    chk_out("w2_i0", 1'b1, 32'd4, 32'd0);
    tick(0, 0, 0);
    chk_out("w2_gap", 1'b0, 0, 0);
    tick(0, 0, 0);
    chk_out("w2_gap", 1'b0, 0, 0);
    tick(0, 0, 0);
    chk_out("w2_i1", 1'b1, 32'd8, 32'd4);
    tick(0, 0, 0);

    // freeze for 4 cycles while streaming
    mem_wait = 0;
    do_reset();
    repeat (4) tick(0, 0, 0);
    chk_out("fz_pre", 1'b1, 32'd12, 32'd8);
    tick(1, 0, 0);
    chk("fz_skid_req", 32'(bus.imemReq), 32'd0);
    chk_out("fz_hold", 1'b1, 32'd12, 32'd8);
    tick(1, 0, 0);
    chk_out("fz_hold", 1'b1, 32'd12, 32'd8);
    tick(1, 0, 0);
    chk_out("fz_hold", 1'b1, 32'd12, 32'd8);
    tick(1, 0, 0);
    chk_out("fz_hold", 1'b1, 32'd12, 32'd8);
    tick(0, 0, 0);
    chk_out("fz_skid_out", 1'b1, 32'd16, 32'd12);
    tick(0, 0, 0);
    chk_out("fz_next", 1'b1, 32'd20, 32'd16);
    tick(0, 0, 0);

    // branch while a 3-wait fetch to 0x8 is in flight
    mem_wait = 3;
    do_reset();
    repeat (5) tick(0, 0, 0);
    chk_out("bf_i0", 1'b1, 32'd4, 32'd0);
    repeat (4) tick(0, 0, 0);
    chk_out("bf_i1", 1'b1, 32'd8, 32'd4);
    chk("bf_addr8", bus.imemAddr, 32'd8);
    tick(0, 1, 32'h100);
    for (int k = 0; k < 3; k++) begin
      chk("bf_drain_req", 32'(bus.imemReq), 32'd1);
      chk("bf_drain_addr", bus.imemAddr, 32'd8);
      chk_out("bf_drain", 1'b0, 0, 0);
      tick(0, 0, 0);
    end
    chk("bf_tgt_req", 32'(bus.imemReq), 32'd1);
    chk("bf_tgt_addr", bus.imemAddr, 32'h100);
    chk_out("bf_discard", 1'b0, 0, 0);
    for (int k = 0; k < 10 && !bus.instValid; k++) tick(0, 0, 0);
    chk_out("bf_target", 1'b1, 32'h104, 32'h100);

    // branch with freeze and both buffers full
    mem_wait = 0;
    do_reset();
    repeat (4) tick(0, 0, 0);
    chk_out("bz_pre", 1'b1, 32'd12, 32'd8);
    tick(1, 0, 0);
    chk("bz_skid_req", 32'(bus.imemReq), 32'd0);
    tick(1, 1, 32'h203);
    chk_out("bz_flush", 1'b0, 0, 0);
    chk("bz_req", 32'(bus.imemReq), 32'd1);
    chk("bz_addr", bus.imemAddr, 32'h200);
    tick(0, 0, 0);
    chk_out("bz_target", 1'b1, 32'h204, 32'h200);
    tick(0, 0, 0);

    // asynchronous reset mid-stream
    rst = 1'b1;
    #1;
    chk("ar_req", 32'(bus.imemReq), 32'd0);
    chk("ar_addr", bus.imemAddr, 32'd0);
    chk("ar_valid", 32'(bus.instValid), 32'd0);
    chk("ar_pc", bus.pcOut, 32'd0);
    chk("ar_inst", bus.inst, 32'd0);

    // wrapping RESET_PC instance
    @(negedge clk);
    rst_w = 1'b0;
    chk("wr_idle", 32'(bw.imemReq), 32'd0);
    @(negedge clk);
    chk("wr_req", 32'(bw.imemReq), 32'd1);
    chk("wr_addr", bw.imemAddr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wr_pc0", bw.pcOut, 32'hFFFF_FFFC);
    chk("wr_inst0", bw.inst, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wr_pc1", bw.pcOut, 32'h0);
    chk("wr_inst1", bw.inst, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wr_pc2", bw.pcOut, 32'h4);
    chk("wr_valid2", 32'(bw.instValid), 32'd1);
    #2;
    rst_w = 1'b1;
    #1;
    chk("wr_rst_valid", 32'(bw.instValid), 32'd0);
    chk("wr_rst_pc", bw.pcOut, 32'd0);
    chk("wr_rst_inst", bw.inst, 32'd0);
    chk("wr_rst_req", 32'(bw.imemReq), 32'd0);
    chk("wr_rst_addr", bw.imemAddr, 32'hFFFF_FFF8);

    // randomized run against the stream scoreboard
    mem_wait = -1; key = 32'hC3A5_96E1;
    do_reset();
    exp_pc = 32'd0; idle_cnt = 0; sb_on = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0, $urandom);
    end
    sb_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
